// File: rtl/montprod_arbiter.sv
// montprod_arbiter
//
// Shares a single montprod instance between two requesters. Each requester
// sees the same calculate/ready/done, operand-memory and result-memory
// interface that montprod exposes. Requests are latched, granted in
// round-robin order, and the owner's memory traffic is routed through
// combinationally while it holds the grant.
//
// Ports
//   clk, reset_n                   clock, asynchronous active-low reset
//   reqN_calculate / reqN_length   request pulse and operand length (N = 0,1)
//   reqN_ready / reqN_done         idle indication, one-cycle completion pulse
//   reqN_op{a,b,m}_addr/_data      operand memory port (registered memory)
//   reqN_result_addr/_data/_we     result memory write port
//   mp_*                           shared montprod instance
//   busy, grant_id                 montprod granted, current/last owner
//
// State table
//   state     | meaning
//   ST_IDLE   | choose an owner among pending requests, latch its length
//   ST_START  | one-cycle calculate pulse to montprod
//   ST_WAIT_LOW | wait (bounded) for montprod to drop ready
//   ST_RUN    | montprod working, wait for ready to return
//   ST_DONE   | done pulse to owner, release its pending flag

module montprod_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  req0_calculate,
    input  logic [ADDR_WIDTH-1:0] req0_length,
    output logic                  req0_ready,
    output logic                  req0_done,
    output logic [ADDR_WIDTH-1:0] req0_opa_addr,
    output logic [ADDR_WIDTH-1:0] req0_opb_addr,
    output logic [ADDR_WIDTH-1:0] req0_opm_addr,
    input  logic [DATA_WIDTH-1:0] req0_opa_data,
    input  logic [DATA_WIDTH-1:0] req0_opb_data,
    input  logic [DATA_WIDTH-1:0] req0_opm_data,
    output logic [ADDR_WIDTH-1:0] req0_result_addr,
    output logic [DATA_WIDTH-1:0] req0_result_data,
    output logic                  req0_result_we,

    input  logic                  req1_calculate,
    input  logic [ADDR_WIDTH-1:0] req1_length,
    output logic                  req1_ready,
    output logic                  req1_done,
    output logic [ADDR_WIDTH-1:0] req1_opa_addr,
    output logic [ADDR_WIDTH-1:0] req1_opb_addr,
    output logic [ADDR_WIDTH-1:0] req1_opm_addr,
    input  logic [DATA_WIDTH-1:0] req1_opa_data,
    input  logic [DATA_WIDTH-1:0] req1_opb_data,
    input  logic [DATA_WIDTH-1:0] req1_opm_data,
    output logic [ADDR_WIDTH-1:0] req1_result_addr,
    output logic [DATA_WIDTH-1:0] req1_result_data,
    output logic                  req1_result_we,

    output logic                  mp_calculate,
    output logic [ADDR_WIDTH-1:0] mp_length,
    input  logic                  mp_ready,
    input  logic [ADDR_WIDTH-1:0] mp_opa_addr,
    input  logic [ADDR_WIDTH-1:0] mp_opb_addr,
    input  logic [ADDR_WIDTH-1:0] mp_opm_addr,
    output logic [DATA_WIDTH-1:0] mp_opa_data,
    output logic [DATA_WIDTH-1:0] mp_opb_data,
    output logic [DATA_WIDTH-1:0] mp_opm_data,
    input  logic [ADDR_WIDTH-1:0] mp_result_addr,
    input  logic [DATA_WIDTH-1:0] mp_result_data,
    input  logic                  mp_result_we,

    output logic                  busy,
    output logic                  grant_id
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_LOW,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_pending;
    logic [ADDR_WIDTH-1:0] r_len0;
    logic [ADDR_WIDTH-1:0] r_len1;
    logic                  r_last_grant;
    logic                  r_grant_id;
    logic [ADDR_WIDTH-1:0] r_mp_length;
    logic [1:0]            r_zero_done;
    logic [1:0]            r_wait_cnt;

    logic [1:0]            w_ready;
    logic [1:0]            w_accept;
    logic [1:0]            w_zero_len;
    logic                  w_pick;
    logic                  w_busy;

    // A requester is ready exactly when it has no job queued or running;
    // its pending flag covers both.
    assign w_ready    = ~r_pending;
    assign w_accept   = {req1_calculate, req0_calculate} & w_ready;
    assign w_zero_len = {(req1_length == '0), (req0_length == '0)};

    // On a tie, the requester that did not own montprod last time wins.
    always_comb begin
        w_pick = r_pending[1];
        if (r_pending == 2'b11) begin
            w_pick = ~r_last_grant;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (r_pending != 2'b00) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                w_state_nxt = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                // montprod that never drops ready within the window is
                // taken as having finished immediately.
                if (!mp_ready) begin
                    w_state_nxt = ST_RUN;
                end else if (r_wait_cnt == 2'd0) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_RUN: begin
                if (mp_ready) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_pending    <= 2'b00;
            r_len0       <= '0;
            r_len1       <= '0;
            r_last_grant <= 1'b1;
            r_grant_id   <= 1'b0;
            r_mp_length  <= '0;
            r_zero_done  <= 2'b00;
            r_wait_cnt   <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            // Zero-length jobs complete without ever touching montprod.
            r_zero_done <= w_accept & w_zero_len;

            if (w_accept[0] && !w_zero_len[0]) begin
                r_pending[0] <= 1'b1;
                r_len0       <= req0_length;
            end
            if (w_accept[1] && !w_zero_len[1]) begin
                r_pending[1] <= 1'b1;
                r_len1       <= req1_length;
            end

            if (r_state == ST_IDLE && r_pending != 2'b00) begin
                r_grant_id  <= w_pick;
                r_mp_length <= w_pick ? r_len1 : r_len0;
            end

            // Four WAIT_LOW cycles: 3,2,1,0 then give up.
            if (r_state == ST_START) begin
                r_wait_cnt <= 2'd3;
            end else if (r_state == ST_WAIT_LOW && r_wait_cnt != 2'd0) begin
                r_wait_cnt <= r_wait_cnt - 2'd1;
            end

            // The owner is never ready here, so this cannot collide with a
            // new accept for the same requester.
            if (r_state == ST_DONE) begin
                r_pending[r_grant_id] <= 1'b0;
                r_last_grant          <= r_grant_id;
            end
        end
    end

    assign w_busy       = (r_state == ST_START) || (r_state == ST_WAIT_LOW) ||
                          (r_state == ST_RUN);
    assign busy         = w_busy;
    assign grant_id     = r_grant_id;
    assign mp_calculate = (r_state == ST_START);
    assign mp_length    = r_mp_length;

    assign req0_ready = w_ready[0];
    assign req1_ready = w_ready[1];
    assign req0_done  = ((r_state == ST_DONE) && !r_grant_id) || r_zero_done[0];
    assign req1_done  = ((r_state == ST_DONE) &&  r_grant_id) || r_zero_done[1];

    // Addresses and write data fan out to both sides; only the owner's
    // write enable is ever raised, and only while montprod is granted.
    assign req0_opa_addr    = mp_opa_addr;
    assign req0_opb_addr    = mp_opb_addr;
    assign req0_opm_addr    = mp_opm_addr;
    assign req0_result_addr = mp_result_addr;
    assign req0_result_data = mp_result_data;
    assign req0_result_we   = mp_result_we && w_busy && !r_grant_id;

    assign req1_opa_addr    = mp_opa_addr;
    assign req1_opb_addr    = mp_opb_addr;
    assign req1_opm_addr    = mp_opm_addr;
    assign req1_result_addr = mp_result_addr;
    assign req1_result_data = mp_result_data;
    assign req1_result_we   = mp_result_we && w_busy && r_grant_id;

    assign mp_opa_data = r_grant_id ? req1_opa_data : req0_opa_data;
    assign mp_opb_data = r_grant_id ? req1_opb_data : req0_opb_data;
    assign mp_opm_data = r_grant_id ? req1_opm_data : req0_opm_data;

endmodule

// File: tb/tb_montprod_arbiter.sv
// tb_montprod_arbiter
//
// Bench for montprod_arbiter. Provides two registered operand/result memories
// and a behavioural montprod (word-wise Montgomery product a*b*2^-32 mod m)
// shared through the arbiter.

module tb_montprod_arbiter;
    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;

    logic          req0_calculate = 1'b0;
    logic [AW-1:0] req0_length = '0;
    logic          req0_ready, req0_done;
    logic [AW-1:0] req0_opa_addr, req0_opb_addr, req0_opm_addr, req0_result_addr;
    logic [DW-1:0] req0_opa_data, req0_opb_data, req0_opm_data, req0_result_data;
    logic          req0_result_we;

    logic          req1_calculate = 1'b0;
    logic [AW-1:0] req1_length = '0;
    logic          req1_ready, req1_done;
    logic [AW-1:0] req1_opa_addr, req1_opb_addr, req1_opm_addr, req1_result_addr;
    logic [DW-1:0] req1_opa_data, req1_opb_data, req1_opm_data, req1_result_data;
    logic          req1_result_we;

    logic          mp_calculate, mp_ready, mp_result_we;
    logic [AW-1:0] mp_length, mp_opa_addr, mp_opb_addr, mp_opm_addr, mp_result_addr;
    logic [DW-1:0] mp_opa_data, mp_opb_data, mp_opm_data, mp_result_data;
    logic          busy, grant_id;

    int checks = 0;
    int failures = 0;

    montprod_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_calculate(req0_calculate), .req0_length(req0_length),
        .req0_ready(req0_ready), .req0_done(req0_done),
        .req0_opa_addr(req0_opa_addr), .req0_opb_addr(req0_opb_addr),
        .req0_opm_addr(req0_opm_addr), .req0_opa_data(req0_opa_data),
        .req0_opb_data(req0_opb_data), .req0_opm_data(req0_opm_data),
        .req0_result_addr(req0_result_addr), .req0_result_data(req0_result_data),
        .req0_result_we(req0_result_we),
        .req1_calculate(req1_calculate), .req1_length(req1_length),
        .req1_ready(req1_ready), .req1_done(req1_done),
        .req1_opa_addr(req1_opa_addr), .req1_opb_addr(req1_opb_addr),
        .req1_opm_addr(req1_opm_addr), .req1_opa_data(req1_opa_data),
        .req1_opb_data(req1_opb_data), .req1_opm_data(req1_opm_data),
        .req1_result_addr(req1_result_addr), .req1_result_data(req1_result_data),
        .req1_result_we(req1_result_we),
        .mp_calculate(mp_calculate), .mp_length(mp_length), .mp_ready(mp_ready),
        .mp_opa_addr(mp_opa_addr), .mp_opb_addr(mp_opb_addr), .mp_opm_addr(mp_opm_addr),
        .mp_opa_data(mp_opa_data), .mp_opb_data(mp_opb_data), .mp_opm_data(mp_opm_data),
        .mp_result_addr(mp_result_addr), .mp_result_data(mp_result_data),
        .mp_result_we(mp_result_we),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // a*b*2^-32 mod m for odd m, a,b < m
    function automatic logic [31:0] mont(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] m);
        logic [63:0] t;
        t = 64'd0;
        for (int i = 0; i < 32; i++) begin
            if (a[i]) t = t + {32'd0, b};
            if (t[0]) t = t + {32'd0, m};
            t = t >> 1;
        end
        if (t >= {32'd0, m}) t = t - {32'd0, m};
        return t[31:0];
    endfunction

    // ---------------- requester memories ----------------
    logic [DW-1:0] mem_a [2][256];
    logic [DW-1:0] mem_b [2][256];
    logic [DW-1:0] mem_m [2][256];
    logic [DW-1:0] mem_r [2][256];
    logic          res_clr = 1'b0;

    always @(posedge clk) begin
        req0_opa_data <= mem_a[0][req0_opa_addr];
        req0_opb_data <= mem_b[0][req0_opb_addr];
        req0_opm_data <= mem_m[0][req0_opm_addr];
        req1_opa_data <= mem_a[1][req1_opa_addr];
        req1_opb_data <= mem_b[1][req1_opb_addr];
        req1_opm_data <= mem_m[1][req1_opm_addr];
        if (res_clr) begin
            for (int i = 0; i < 256; i++) begin
                mem_r[0][i] <= 32'hdeadbeef;
                mem_r[1][i] <= 32'hdeadbeef;
            end
        end else begin
            if (req0_result_we) mem_r[0][req0_result_addr] <= req0_result_data;
            if (req1_result_we) mem_r[1][req1_result_addr] <= req1_result_data;
        end
    end

    // ---------------- behavioural montprod ----------------
    int            m_mode;
    logic [AW-1:0] m_len, m_idx;
    logic          mp_ignore = 1'b0;
    logic          mp_glitch = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mp_ready <= 1'b1; m_mode <= 0; mp_result_we <= 1'b0;
            mp_opa_addr <= '0; mp_opb_addr <= '0; mp_opm_addr <= '0;
            mp_result_addr <= '0; mp_result_data <= '0; m_len <= '0; m_idx <= '0;
        end else begin
            case (m_mode)
                0: begin
                    mp_result_we <= mp_glitch;
                    if (mp_calculate && !mp_ignore) begin
                        mp_ready <= 1'b0; m_len <= mp_length; m_idx <= '0;
                        mp_opa_addr <= '0; mp_opb_addr <= '0; mp_opm_addr <= '0;
                        m_mode <= 1;
                    end
                end
                1: m_mode <= 2;
                2: begin
                    mp_result_addr <= m_idx;
                    mp_result_data <= mont(mp_opa_data, mp_opb_data, mp_opm_data);
                    mp_result_we   <= 1'b1;
                    m_mode <= 3;
                end
                default: begin
                    mp_result_we <= 1'b0;
                    if (32'(m_idx) + 1 < 32'(m_len)) begin
                        m_idx <= m_idx + 8'd1;
                        mp_opa_addr <= m_idx + 8'd1;
                        mp_opb_addr <= m_idx + 8'd1;
                        mp_opm_addr <= m_idx + 8'd1;
                        m_mode <= 1;
                    end else begin
                        mp_ready <= 1'b1;
                        m_mode <= 0;
                    end
                end
            endcase
        end
    end

    // ---------------- event monitor ----------------
    int n_calc = 0, n_done0 = 0, n_done1 = 0, n_we0 = 0, n_we1 = 0;
    int gq[$];

    always @(negedge clk) begin
        if (mp_calculate) begin
            n_calc++;
            gq.push_back(int'(grant_id));
        end
        if (req0_done) n_done0++;
        if (req1_done) n_done1++;
        if (req0_result_we) n_we0++;
        if (req1_result_we) n_we1++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_results();
        res_clr = 1'b1;
        step();
        res_clr = 1'b0;
    endtask

    task automatic load_word(input int n, input int w, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] m);
        mem_a[n][w] = a; mem_b[n][w] = b; mem_m[n][w] = m;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL reset_req0_ready got=%b exp=1", req0_ready); end
        checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL reset_req1_ready got=%b exp=1", req1_ready); end
        checks++; if ({req0_done, req1_done} !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", {req0_done, req1_done}); end
        checks++; if (mp_calculate !== 1'b0) begin failures++; $display("FAIL reset_mp_calculate got=%b exp=0", mp_calculate); end
        checks++; if (mp_length !== 8'd0) begin failures++; $display("FAIL reset_mp_length got=%0d exp=0", mp_length); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (grant_id !== 1'b0) begin failures++; $display("FAIL reset_grant_id got=%b exp=0", grant_id); end
    endtask

    task automatic test_req0_single();
        int b_calc, b_d0, b_d1, b_we1, k;
        load_word(0, 0, 32'h9, 32'h7, 32'h13);
        clear_results();
        b_calc = n_calc; b_d0 = n_done0; b_d1 = n_done1; b_we1 = n_we1;
        req0_length = 8'd1; req0_calculate = 1'b1;
        step();
        req0_calculate = 1'b0;
        checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL r0_ready_drop got=%b exp=0", req0_ready); end
        checks++; if (mp_calculate !== 1'b0) begin failures++; $display("FAIL r0_calc_early got=%b exp=0", mp_calculate); end
        step();
        checks++; if (mp_calculate !== 1'b1) begin failures++; $display("FAIL r0_calc_latency got=%b exp=1", mp_calculate); end
        checks++; if (grant_id !== 1'b0 || busy !== 1'b1 || mp_length !== 8'd1) begin
            failures++; $display("FAIL r0_grant got=gid%b busy%b len%0d exp=gid0 busy1 len1", grant_id, busy, mp_length); end
        for (k = 0; k < 100 && n_done0 == b_d0; k++) step();
        checks++; if (n_done0 == b_d0) begin failures++; $display("FAIL r0_done_timeout got=none exp=pulse"); end
        step();
        checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL r0_ready_back got=%b exp=1", req0_ready); end
        checks++; if (mem_r[0][0] !== 32'h00000001) begin failures++; $display("FAIL r0_result got=%h exp=00000001", mem_r[0][0]); end
        checks++; if (n_calc - b_calc != 1 || n_done0 - b_d0 != 1) begin
            failures++; $display("FAIL r0_counts got=calc%0d done%0d exp=1 1", n_calc - b_calc, n_done0 - b_d0); end
        checks++; if (n_we1 != b_we1 || n_done1 != b_d1) begin
            failures++; $display("FAIL r0_req1_quiet got=we%0d done%0d exp=0 0", n_we1 - b_we1, n_done1 - b_d1); end
    endtask

    task automatic test_req1_single();
        int b_d0, b_d1, b_we0, k;
        load_word(1, 0, 32'h2, 32'ha, 32'h0b);
        clear_results();
        b_d0 = n_done0; b_d1 = n_done1; b_we0 = n_we0;
        req1_length = 8'd1; req1_calculate = 1'b1;
        step();
        req1_calculate = 1'b0;
        step();
        checks++; if (mp_calculate !== 1'b1 || grant_id !== 1'b1) begin
            failures++; $display("FAIL r1_grant got=calc%b gid%b exp=calc1 gid1", mp_calculate, grant_id); end
        for (k = 0; k < 100 && n_done1 == b_d1; k++) step();
        checks++; if (n_done1 - b_d1 != 1) begin failures++; $display("FAIL r1_done got=%0d exp=1", n_done1 - b_d1); end
        step();
        checks++; if (mem_r[1][0] !== 32'h00000005) begin failures++; $display("FAIL r1_result got=%h exp=00000005", mem_r[1][0]); end
        checks++; if (grant_id !== 1'b1) begin failures++; $display("FAIL r1_last_owner got=%b exp=1", grant_id); end
        checks++; if (n_we0 != b_we0 || n_done0 != b_d0) begin
            failures++; $display("FAIL r1_req0_quiet got=we%0d done%0d exp=0 0", n_we0 - b_we0, n_done0 - b_d0); end
    endtask

    task automatic run_pair(input string name, input int first);
        int b_q, b_d0, b_d1, k, s0, s1;
        load_word(0, 0, 32'h9, 32'h7, 32'h13);
        load_word(1, 0, 32'hb, 32'h2, 32'h11);
        clear_results();
        b_q = gq.size(); b_d0 = n_done0; b_d1 = n_done1;
        req0_length = 8'd1; req1_length = 8'd1;
        req0_calculate = 1'b1; req1_calculate = 1'b1;
        step();
        req0_calculate = 1'b0; req1_calculate = 1'b0;
        for (k = 0; k < 200 && (n_done0 == b_d0 || n_done1 == b_d1); k++) step();
        step();
        checks++; if (n_done0 - b_d0 != 1 || n_done1 - b_d1 != 1) begin
            failures++; $display("FAIL %s_done got=%0d %0d exp=1 1", name, n_done0 - b_d0, n_done1 - b_d1); end
        s0 = (gq.size() > b_q) ? gq[b_q] : -1;
        s1 = (gq.size() > b_q + 1) ? gq[b_q + 1] : -1;
        checks++; if (s0 != first || s1 != 1 - first) begin
            failures++; $display("FAIL %s_order got=%0d,%0d exp=%0d,%0d", name, s0, s1, first, 1 - first); end
        checks++; if (mem_r[0][0] !== 32'h1 || mem_r[1][0] !== 32'h5) begin
            failures++; $display("FAIL %s_results got=%h %h exp=00000001 00000005", name, mem_r[0][0], mem_r[1][0]); end
    endtask

    task automatic test_repeat_ignored();
        int b_calc, b_d0, k;
        load_word(0, 0, 32'h9, 32'h7, 32'h13);
        b_calc = n_calc; b_d0 = n_done0;
        req0_length = 8'd1; req0_calculate = 1'b1;
        // held through the whole job, including the done cycle
        for (k = 0; k < 100 && !req0_done; k++) step();
        step();
        req0_calculate = 1'b0;
        for (k = 0; k < 10; k++) step();
        checks++; if (n_calc - b_calc != 1) begin failures++; $display("FAIL repeat_calc got=%0d exp=1", n_calc - b_calc); end
        checks++; if (n_done0 - b_d0 != 1) begin failures++; $display("FAIL repeat_done got=%0d exp=1", n_done0 - b_d0); end
        checks++; if (req0_ready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL repeat_idle got=ready%b busy%b exp=1 0", req0_ready, busy); end
    endtask

    task automatic test_zero_length();
        int b_calc;
        b_calc = n_calc;
        req0_length = 8'd0; req0_calculate = 1'b1;
        step();
        req0_calculate = 1'b0;
        checks++; if (req0_done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", req0_done); end
        checks++; if (req0_ready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL zero_state got=ready%b busy%b exp=1 0", req0_ready, busy); end
        step();
        checks++; if (req0_done !== 1'b0) begin failures++; $display("FAIL zero_done_width got=%b exp=0", req0_done); end
        for (int k = 0; k < 8; k++) step();
        checks++; if (n_calc != b_calc) begin failures++; $display("FAIL zero_no_calc got=%0d exp=0", n_calc - b_calc); end
    endtask

    task automatic test_wait_low_timeout();
        int k, b_we1;
        b_we1 = n_we1;
        mp_ignore = 1'b1;
        req1_length = 8'd1; req1_calculate = 1'b1;
        step();
        req1_calculate = 1'b0;
        for (k = 0; k < 20 && !mp_calculate; k++) step();
        for (k = 0; k < 20 && !req1_done; ) begin step(); k++; end
        checks++; if (k != 5) begin failures++; $display("FAIL timeout_cycles got=%0d exp=5", k); end
        step();
        mp_ignore = 1'b0;
        checks++; if (req1_ready !== 1'b1 || n_we1 != b_we1) begin
            failures++; $display("FAIL timeout_state got=ready%b we%0d exp=1 0", req1_ready, n_we1 - b_we1); end
    endtask

    task automatic test_we_glitch();
        int b0, b1;
        b0 = n_we0; b1 = n_we1;
        mp_glitch = 1'b1;
        for (int k = 0; k < 4; k++) step();
        mp_glitch = 1'b0;
        step(); step();
        checks++; if (n_we0 != b0 || n_we1 != b1) begin
            failures++; $display("FAIL glitch_we got=%0d %0d exp=0 0", n_we0 - b0, n_we1 - b1); end
    endtask

    task automatic test_reset_mid();
        int k, b_d0, b_d1;
        load_word(0, 0, 32'h9, 32'h7, 32'h13);
        load_word(0, 1, 32'h9, 32'h7, 32'h13);
        req0_length = 8'd2; req0_calculate = 1'b1;
        step();
        req0_calculate = 1'b0;
        for (k = 0; k < 20 && mp_ready; k++) step();
        step();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy_before got=%b exp=1", busy); end
        b_d0 = n_done0; b_d1 = n_done1;
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || req0_ready !== 1'b1 || req1_ready !== 1'b1) begin
            failures++; $display("FAIL rst_mid_state got=busy%b r0%b r1%b exp=0 1 1", busy, req0_ready, req1_ready); end
        step(); step(); step();
        reset_n = 1'b1;
        for (k = 0; k < 20; k++) step();
        checks++; if (n_done0 != b_d0 || n_done1 != b_d1) begin
            failures++; $display("FAIL rst_mid_no_done got=%0d %0d exp=0 0", n_done0 - b_d0, n_done1 - b_d1); end
        clear_results();
        b_d0 = n_done0;
        req0_length = 8'd1; req0_calculate = 1'b1;
        step();
        req0_calculate = 1'b0;
        for (k = 0; k < 100 && n_done0 == b_d0; k++) step();
        step();
        checks++; if (n_done0 - b_d0 != 1 || mem_r[0][0] !== 32'h1) begin
            failures++; $display("FAIL rst_mid_fresh got=done%0d res%h exp=1 00000001", n_done0 - b_d0, mem_r[0][0]); end
    endtask

    task automatic test_random();
        localparam int JOBS = 6;
        int issued[2], served[2], lens[2], k, b_d0, b_d1;
        bit outst[2], just_done[2];
        logic [31:0] exp_r[2][4];
        logic [31:0] a, b, m;
        logic dn;
        issued = '{0, 0}; served = '{0, 0}; outst = '{0, 0}; lens = '{1, 1};
        b_d0 = n_done0; b_d1 = n_done1;
        for (k = 0; k < 8000 && (served[0] < JOBS || served[1] < JOBS); k++) begin
            step();
            req0_calculate = 1'b0; req1_calculate = 1'b0;
            for (int n = 0; n < 2; n++) begin
                dn = (n == 0) ? req0_done : req1_done;
                just_done[n] = 1'b0;
                if (dn) begin
                    checks++;
                    if (!outst[n]) begin
                        failures++; $display("FAIL rand_spurious_done req%0d", n);
                    end else begin
                        for (int w = 0; w < lens[n]; w++)
                            if (mem_r[n][w] !== exp_r[n][w]) begin
                                failures++;
                                $display("FAIL rand_result req%0d job%0d word%0d got=%h exp=%h",
                                         n, served[n], w, mem_r[n][w], exp_r[n][w]);
                                break;
                            end
                        served[n]++;
                    end
                    outst[n] = 1'b0;
                    just_done[n] = 1'b1;
                end
            end
            for (int n = 0; n < 2; n++) begin
                if (!outst[n] && !just_done[n] && issued[n] < JOBS && $urandom_range(0, 3) == 0) begin
                    lens[n] = int'($urandom_range(1, 3));
                    for (int w = 0; w < lens[n]; w++) begin
                        m = $urandom | 32'h1;
                        a = $urandom % m;
                        b = $urandom % m;
                        load_word(n, w, a, b, m);
                        exp_r[n][w] = mont(a, b, m);
                    end
                    if (n == 0) begin req0_length = 8'(lens[n]); req0_calculate = 1'b1; end
                    else begin req1_length = 8'(lens[n]); req1_calculate = 1'b1; end
                    outst[n] = 1'b1;
                    issued[n]++;
                end
            end
        end
        req0_calculate = 1'b0; req1_calculate = 1'b0;
        checks++; if (served[0] != JOBS || served[1] != JOBS) begin
            failures++; $display("FAIL rand_served got=%0d %0d exp=%0d %0d", served[0], served[1], JOBS, JOBS); end
        checks++; if (n_done0 - b_d0 != JOBS || n_done1 - b_d1 != JOBS) begin
            failures++; $display("FAIL rand_done_count got=%0d %0d exp=%0d %0d",
                                 n_done0 - b_d0, n_done1 - b_d1, JOBS, JOBS); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        step(); step(); step();
        test_reset();
        reset_n = 1'b1;
        step();
        test_req0_single();
        test_req1_single();
        run_pair("pair1", 0);
        test_repeat_ignored();
        run_pair("pair2", 1);
        test_zero_length();
        test_wait_low_timeout();
        test_we_glitch();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
